seg_bcd_arb: RTL
================

# seg_bcd_arb

Display-sharing arbiter in front of the 6-digit BCD seven-segment path. It owns the 24-bit `seg_bcd` bus and grants it to one of three sources:
- ch0: time-of-day, the default owner.
- ch1: alarm/setting view.
- ch2: stopwatch/alert view.

It enforces a minimum hold time per grant and, optionally, blinks selected digits of the granted source. Its `seg_bcd` output drives the display path's 24-bit BCD input directly.

## Interface
- `CLK_FREQ`, 50_000_000: clock frequency in Hz; one ms tick every CLK_FREQ/1000 cycles.
- `HOLD_MS`, 2000: minimum display time, in ms, once ch1/ch2 is granted.
- `BLINK_HALF_MS`, 500: blink half-period in ms.
- `BLANK_CODE`, 4'hF: nibble substituted for a blanked digit.
- `clk`  in  1: system clock.
- `rst_n`  in  1: synchronous, active-low reset.
- `req1`, `req2`  in  1 each: level requests for ch1/ch2; ch0 is implicitly always requesting.
- `bcd0`, `bcd1`, `bcd2`  in  24 each: per-channel digits; bits [23:20] are the leftmost digit.
- `blink0`, `blink1`, `blink2`  in  6 each: per-channel blink mask; bit 5 is the leftmost digit.
- `seg_bcd`  out  24: registered display digits.
- `grant`  out  3: one-hot owner; bit k means channel k.
- `busy`  out  1: 1 while ch1 or ch2 is granted.

## Operation
- **Priority:** ch2 > ch1 > ch0. Simultaneous `req1` and `req2` resolve to ch2.
- **FSM states:**
  - `S_CH0`: grant=001. Any request → `S_LOCK` with the winning channel; hold counter loads HOLD_MS.
  - `S_LOCK`: grant is held and cannot be preempted, including by a higher-priority channel. The hold counter decrements on each ms tick. When it reaches 0 → `S_OPEN`.
  - `S_OPEN`: re-arbitrate every cycle.
    - A higher-priority request than the current owner → `S_LOCK` with that channel.
    - The owner's request drops → `S_LOCK` with the highest pending ch1/ch2, else `S_CH0`.
    - Otherwise stay.
- **Request dropped during `S_LOCK`:** the grant is still held until the counter expires. The transition is then evaluated in `S_OPEN` on the next cycle.
- **Output mux:** `seg_bcd` = digits of the granted channel, with blanking applied.
- **Blanking:** digit i is replaced by BLANK_CODE when blink bit i is 1 and blink_phase=1.
- **Blink phase:** toggles on every BLINK_HALF_MS-th ms tick. It resets to 0 (visible) on every grant change, so a newly granted view always starts visible.
- **Counter widths:** hold counter is `$clog2(HOLD_MS+1)` bits; blink counter is `$clog2(BLINK_HALF_MS)` bits. Both wrap explicitly to their reload values and never free-wrap.

## Timing
- **Reset** (`rst_n` low at a rising edge):
  - Outputs: grant=001, `seg_bcd`=24'h000000, busy=0.
  - Internal: state `S_CH0`, blink_phase=0, all counters 0.
  - Reset applied mid-hold aborts the hold immediately.
- **Request latency:**
  - `req` sampled at edge N → `grant`/`busy` change at edge N+1.
  - `seg_bcd` reflects the new owner at edge N+2; it is registered from the registered grant.
- **Data latency:** a channel's data or mask change appears on `seg_bcd` one cycle later while that channel is granted.
- **ms tick:** one-cycle pulse, first asserted CLK_FREQ/1000 cycles after reset release. Hold duration is HOLD_MS ticks, with jitter ≤ 1 tick.
- **Grant-change cycle:** blink_phase=0 in the same cycle that grant changes. The blink counter restarts.

## Configuration
- Macro: `SEG_BCD_ARB_BLINK_EN`.
- **Defined:** blink counter, blink_phase and per-digit blanking are present as described above.
- **Undefined:**
  - `blink0`/`blink1`/`blink2` ports remain but are ignored.
  - `seg_bcd` is always the unmodified granted data.
  - No blink logic is synthesized.

## Structure
- **Package `seg_pkg`:**
  - Channel index constants `CH_TIME`=0, `CH_ALARM`=1, `CH_SW`=2.
  - State enum `arb_state_t` {`S_CH0`, `S_LOCK`, `S_OPEN`}.
  - Default `BLANK_CODE`.
- **Sub-module `seg_ms_tick`:** CLK_FREQ/1000 prescaler with synchronous active-low reset, emitting a one-cycle `tick_ms`.
- **Main module:** FSM, hold counter, blink counter and output register.

## Test plan
Run with `CLK_FREQ`=10_000 (10 cycles/ms), `HOLD_MS`=3, `BLINK_HALF_MS`=2.
- **Reset:** assert `rst_n`=0 with `req2`=1 → grant=001, `seg_bcd`=0, busy=0. On release with `bcd0`=24'h123456 → `seg_bcd`=24'h123456 two cycles later.
- **Simultaneous requests:** `req1` and `req2` rise in the same cycle with `bcd2`=24'h000999 → grant=100 next edge; `seg_bcd`=24'h000999 the edge after.
- **Hold lock:**
  - Grant ch1, then raise `req2` 1 ms later → grant stays 010 until 3 ticks have elapsed; grant becomes 100 one cycle after entering `S_OPEN`.
  - `req1` pulsed for 1 cycle → ch1 shown for 3 ms, then grant=001.
- **Blink** (macro defined): ch0 granted, `blink0`=6'b110000, `bcd0`=24'h235959 → `seg_bcd` alternates 24'h235959 and 24'hFF5959 every 2 ms. Phase is visible immediately after any grant change.
- **Blink compiled out** (macro undefined): same stimulus → `seg_bcd` constant at 24'h235959.
- **Reset mid-hold:** `rst_n`=0 while in `S_LOCK` on ch2 → grant=001 next edge. With `req2` still high after release, ch2 is re-granted after one cycle with a fresh 3 ms hold.

Source files
------------

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants, state enum and helpers for the display arbiter
package seg_pkg;

  localparam int CH_TIME  = 0;
  localparam int CH_ALARM = 1;
  localparam int CH_SW    = 2;

  typedef enum logic [1:0] {
    S_CH0,
    S_LOCK,
    S_OPEN
  } arb_state_t;

  localparam logic [3:0] DEFAULT_BLANK_CODE = 4'hF;

  // One-hot grant vector for a channel index.
  function automatic logic [2:0] ch_onehot(input logic [1:0] ch);
    return 3'b001 << ch;
  endfunction

endpackage

// File: rtl/seg_ms_tick.sv
// rtl/seg_ms_tick.sv - CLK_FREQ/1000 prescaler producing a one-cycle millisecond tick
module seg_ms_tick #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_ms
);

  localparam int DIV = (CLK_FREQ / 1000 > 1) ? CLK_FREQ / 1000 : 2;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running divider, wrapped explicitly at DIV-1.
  always_ff @(posedge clk) begin
    if (!rst_n)           cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

  assign tick_ms = (cnt == LAST);

endmodule

// File: rtl/seg_bcd_arb.sv
// rtl/seg_bcd_arb.sv - display-sharing arbiter with hold lock; SEG_BCD_ARB_BLINK_EN enables digit blinking
module seg_bcd_arb
  import seg_pkg::*;
#(
  parameter int         CLK_FREQ      = 50_000_000,
  parameter int         HOLD_MS       = 2000,
  parameter int         BLINK_HALF_MS = 500,
  parameter logic [3:0] BLANK_CODE    = DEFAULT_BLANK_CODE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req1,
  input  logic        req2,
  input  logic [23:0] bcd0,
  input  logic [23:0] bcd1,
  input  logic [23:0] bcd2,
  input  logic [5:0]  blink0,
  input  logic [5:0]  blink1,
  input  logic [5:0]  blink2,
  output logic [23:0] seg_bcd,
  output logic [2:0]  grant,
  output logic        busy
);

  localparam int HW = $clog2(HOLD_MS + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_MS);

  logic tick_ms;

  seg_ms_tick #(.CLK_FREQ(CLK_FREQ)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick_ms (tick_ms)
  );

  arb_state_t    state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0]    winner;
  logic          owner_req;

  // State, owner and hold counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_CH0;
      owner_q <= 2'(CH_TIME);
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
    end
  end

  // Arbitration: fixed priority ch2 > ch1, lock for HOLD_MS ticks, then re-arbitrate.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    hold_d    = hold_q;
    winner    = req2 ? 2'(CH_SW) : (req1 ? 2'(CH_ALARM) : 2'(CH_TIME));
    owner_req = (owner_q == 2'(CH_SW)) ? req2 : req1;
    case (state_q)
      S_CH0: begin
        if (req1 || req2) begin
          state_d = S_LOCK;
          owner_d = winner;
          hold_d  = HOLD_LOAD;
        end
      end
      S_LOCK: begin
        if (hold_q == '0)  state_d = S_OPEN;
        else if (tick_ms)  hold_d  = hold_q - HW'(1);
      end
      S_OPEN: begin
        if (owner_q == 2'(CH_ALARM) && req2) begin
          state_d = S_LOCK;
          owner_d = 2'(CH_SW);
          hold_d  = HOLD_LOAD;
        end else if (!owner_req) begin
          if (winner != 2'(CH_TIME)) begin
            state_d = S_LOCK;
            owner_d = winner;
            hold_d  = HOLD_LOAD;
          end else begin
            state_d = S_CH0;
            owner_d = 2'(CH_TIME);
            hold_d  = '0;
          end
        end
      end
      default: begin
        state_d = S_CH0;
        owner_d = 2'(CH_TIME);
        hold_d  = '0;
      end
    endcase
  end

  assign grant = ch_onehot(owner_q);
  assign busy  = (state_q != S_CH0);

  logic [23:0] data_sel;
  logic [23:0] seg_d;

  // Source data of the currently granted channel.
  always_comb begin
    case (owner_q)
      2'(CH_ALARM): data_sel = bcd1;
      2'(CH_SW):    data_sel = bcd2;
      default:      data_sel = bcd0;
    endcase
  end

`ifdef SEG_BCD_ARB_BLINK_EN
  localparam int BW = (BLINK_HALF_MS > 1) ? $clog2(BLINK_HALF_MS) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_MS - 1);

  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic [5:0]    mask_sel;

  // Blink phase restarts visible whenever the owner changes at this edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (owner_d != owner_q) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (tick_ms) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  // Blink mask of the granted channel and per-digit blanking.
  always_comb begin
    case (owner_q)
      2'(CH_ALARM): mask_sel = blink1;
      2'(CH_SW):    mask_sel = blink2;
      default:      mask_sel = blink0;
    endcase
    seg_d = data_sel;
    for (int i = 0; i < 6; i++) begin
      if (mask_sel[i] && blink_phase) seg_d[i*4 +: 4] = BLANK_CODE;
    end
  end
`else
  logic unused_blink;
  assign unused_blink = ^{blink0, blink1, blink2};

  // Without blinking the granted data passes through unchanged.
  always_comb begin
    seg_d = data_sel;
  end
`endif

  // Registered display output.
  always_ff @(posedge clk) begin
    if (!rst_n) seg_bcd <= '0;
    else        seg_bcd <= seg_d;
  end

endmodule
